// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 single-precision multiplier, 24-step shift-add mantissa loop.
// Define FP_MUL_ROUND_EN for round-to-nearest-even; default truncates.
module fp_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A_FP,
    input  logic [31:0] B_FP,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] P_FP,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_p;
    logic [4:0]  r_cnt;
    logic [47:0] r_prod;
    logic [23:0] r_mcand;
    logic [23:0] r_mplier;
    logic [9:0]  r_exp;
    logic        r_sign;
    logic        r_zero;
    logic        r_inf;
    logic        r_nan;

    logic [7:0]  w_a_exp;
    logic [7:0]  w_b_exp;
    logic        w_a_man_nz;
    logic        w_b_man_nz;
    logic [24:0] w_sum;
    logic        w_hi;
    logic [22:0] w_man_t;
    logic [9:0]  w_exp_n;
    logic [9:0]  w_exp_f;
    logic [22:0] w_man_f;
    logic [31:0] w_res;

    assign w_a_exp    = A_FP[30:23];
    assign w_b_exp    = B_FP[30:23];
    assign w_a_man_nz = |A_FP[22:0];
    assign w_b_man_nz = |B_FP[22:0];

    // Add multiplicand into the upper half, keep the carry, shift right by one
    assign w_sum = {1'b0, r_prod[47:24]}
                 + (r_mplier[0] ? {1'b0, r_mcand} : 25'd0);

    assign w_hi    = r_prod[47];
    assign w_man_t = w_hi ? r_prod[46:24] : r_prod[45:23];
    assign w_exp_n = r_exp + {9'd0, w_hi};

`ifdef FP_MUL_ROUND_EN
    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;
    logic [23:0] w_man_r;

    assign w_guard  = w_hi ? r_prod[23] : r_prod[22];
    assign w_sticky = w_hi ? (|r_prod[22:0]) : (|r_prod[21:0]);
    assign w_inc    = w_guard & (w_sticky | w_man_t[0]);
    assign w_man_r  = {1'b0, w_man_t} + {23'd0, w_inc};
    // Carry-out leaves mantissa bits all zero, only the exponent bumps
    assign w_exp_f  = w_exp_n + {9'd0, w_man_r[23]};
    assign w_man_f  = w_man_r[22:0];
`else
    assign w_exp_f  = w_exp_n;
    assign w_man_f  = w_man_t;
`endif

    always_comb begin
        w_res = {r_sign, w_exp_f[7:0], w_man_f};
        if (r_nan || (r_inf && r_zero)) begin
            w_res = 32'h7FC0_0000;
        end else if (r_zero) begin
            w_res = {r_sign, 31'd0};
        end else if (r_inf) begin
            w_res = {r_sign, 8'hFF, 23'd0};
        end else if ($signed(w_exp_f) >= $signed(10'd255)) begin
            w_res = {r_sign, 8'hFF, 23'd0};
        end else if ($signed(w_exp_f) <= $signed(10'd0)) begin
            w_res = {r_sign, 31'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_p         <= 32'd0;
            r_cnt       <= 5'd0;
            r_prod      <= 48'd0;
            r_mcand     <= 24'd0;
            r_mplier    <= 24'd0;
            r_exp       <= 10'd0;
            r_sign      <= 1'b0;
            r_zero      <= 1'b0;
            r_inf       <= 1'b0;
            r_nan       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_state    <= MUL;
                        r_in_ready <= 1'b0;
                        r_cnt      <= 5'd0;
                        r_prod     <= 48'd0;
                        r_sign     <= A_FP[31] ^ B_FP[31];
                        r_exp      <= {2'b00, w_a_exp} + {2'b00, w_b_exp}
                                    - 10'd127;
                        r_mcand    <= {1'b1, A_FP[22:0]};
                        r_mplier   <= {1'b1, B_FP[22:0]};
                        r_zero     <= (w_a_exp == 8'd0) || (w_b_exp == 8'd0);
                        r_inf      <= ((w_a_exp == 8'hFF) && !w_a_man_nz)
                                   || ((w_b_exp == 8'hFF) && !w_b_man_nz);
                        r_nan      <= ((w_a_exp == 8'hFF) && w_a_man_nz)
                                   || ((w_b_exp == 8'hFF) && w_b_man_nz);
                    end
                end
                MUL: begin
                    r_prod   <= {w_sum, r_prod[23:1]};
                    r_mplier <= {1'b0, r_mplier[23:1]};
                    if (r_cnt == 5'd23) begin
                        r_state <= NORM;
                        r_cnt   <= 5'd0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                NORM: begin
                    r_p         <= w_res;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign P_FP      = r_p;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: latency, products, specials, backpressure, reset.
// Honours FP_MUL_ROUND_EN for the rounding vector.
module tb_fp_mul_seq;

    logic        clk;
    logic        rst;
    logic [31:0] A_FP;
    logic [31:0] B_FP;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] P_FP;
    logic        out_valid;
    logic        out_ready;

    int n_err;
    int n_chk;

    fp_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .A_FP      (A_FP),
        .B_FP      (B_FP),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .P_FP      (P_FP),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; acceptance happens on the following posedge.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        A_FP     = a;
        B_FP     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A_FP     = 32'hDEAD_BEEF;
        B_FP     = 32'h1234_5678;
    endtask

    // Entered 1 time unit after the acceptance edge; ends at negedge after edge 25.
    task automatic wait_result(input string tag, input logic [31:0] exp);
        repeat (24) @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid_early"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk(tag, P_FP, exp);
    endtask

    task automatic handshake(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic op(input string tag, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
        start(a, b);
        wait_result(tag, exp);
        handshake(tag);
    endtask

    logic [31:0] held;
    logic        seen_valid;

    initial begin
        n_err     = 0;
        n_chk     = 0;
        rst       = 1'b1;
        A_FP      = 32'd0;
        B_FP      = 32'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_p", P_FP, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op("2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
        op("1p5sq", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
        op("neg", 32'hBF00_0000, 32'h4080_0000, 32'hC000_0000);
        op("zero", 32'h0000_0000, 32'h42F6_0000, 32'h0000_0000);
        op("ovf", 32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
        op("inf0", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
        op("nan", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
        op("ninf", 32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
        op("unf", 32'h0080_0000, 32'h8080_0000, 32'h8000_0000);
`ifdef FP_MUL_ROUND_EN
        op("round", 32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0002);
`else
        op("round", 32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0001);
`endif

        out_ready = 1'b0;
        start(32'h3FC0_0000, 32'h4000_0000);
        wait_result("bp", 32'h4040_0000);
        held = P_FP;
        for (int i = 0; i < 10; i++) begin
            A_FP     = 32'h4000_0000;
            B_FP     = 32'h4000_0000;
            in_valid = i[0];
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_p", P_FP, held);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        handshake("bp");
        op("after_bp", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);

        start(32'h4000_0000, 32'h4040_0000);
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        seen_valid = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid;
        end
        chk("mrst_no_output", {31'd0, seen_valid}, 32'd0);
        op("post_rst", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_mul_seq.md
# fp_mul_seq

Multi-cycle IEEE-754 single-precision multiplier that forms the weight×activation products consumed by the floating-point adder in the CNN dot-product datapath. Operands are accepted over a valid/ready handshake, and the mantissa product is built by a 24-iteration shift-add loop. The packed 32-bit product is presented on a valid/ready output that feeds the adder's operand input. Fixed latency trades throughput for a small, single-adder footprint.

## Interface
- No parameters. Format is fixed at 1/8/23 (sign/exponent/mantissa), bias 127.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- A_FP  in  32  operand A (activation), packed IEEE-754.
- B_FP  in  32  operand B (weight), packed IEEE-754.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- P_FP  out  32  product, packed IEEE-754; registered.
- out_valid  out  1  P_FP valid.
- out_ready  in  1  downstream adder accepts P_FP.

## Operation
- States: IDLE, MUL, NORM, DONE.
- IDLE: in_ready=1. Accept on in_valid&&in_ready, then go to MUL. Latch the following at acceptance:
  - sign = A[31]^B[31];
  - 10-bit signed exponent sum eA+eB-127;
  - fractions {1,mant};
  - special-case flags.
- MUL: exactly 24 iterations, one per cycle, iteration counter 0..23. Each iteration examines one multiplier bit, LSB first, conditionally adds the 24-bit multiplicand into a 48-bit partial product, and shifts. Special-case operands still run all 24 iterations, so latency is constant.
- NORM (1 cycle):
  - If product[47]=1: mantissa = product[46:24], exponent +1.
  - Otherwise: mantissa = product[45:23].
  - Exponent >= 255 gives signed infinity (exp 255, mant 0).
  - Exponent <= 0 gives signed zero; denormal results are flushed.
- Special cases, applied in NORM and overriding the arithmetic result:
  - Either exponent 0: signed zero (denormal inputs are treated as zero).
  - Either operand NaN (exp 255, mant != 0): 0x7FC00000.
  - inf×0: 0x7FC00000.
  - inf×finite-nonzero: signed infinity.
- DONE: out_valid=1 and P_FP held stable. On out_valid&&out_ready, go to IDLE.
- Reset values: state IDLE, in_ready=1, out_valid=0, P_FP=0x00000000, counter 0, partial product 0.
- rst mid-operation (any state) abandons the operation: no output is produced and the block is in IDLE the next cycle.
- in_valid is ignored outside IDLE. Operand inputs are sampled only at acceptance and may change afterwards.

## Timing
- Acceptance edge = cycle 0. MUL occupies cycles 1–24, NORM cycle 25, and out_valid rises at cycle 26.
- With out_ready held high, the output handshake completes at cycle 26, IDLE is reached at cycle 27, and the next acceptance can occur at cycle 27 (27-cycle throughput).
- Backpressure: DONE holds indefinitely with P_FP and out_valid stable. in_ready stays 0 throughout.
- out_ready is ignored while out_valid=0.

## Configuration
- FP_MUL_ROUND_EN defined: NORM rounds to nearest, ties to even, using guard = first discarded bit and sticky = OR of the remaining discarded bits.
  - A mantissa carry-out renormalises (exponent +1, mantissa 0).
  - The overflow check is applied after rounding.
  - Latency is unchanged.
- FP_MUL_ROUND_EN undefined: discarded bits are truncated (round toward zero), matching the truncating adder.

## Test plan
- 0x40000000 × 0x40400000 (2.0×3.0), out_ready=1 → P_FP=0x40C00000 with out_valid at cycle 26, and in_ready high again at cycle 27.
- 0x3FC00000 × 0x3FC00000 (1.5×1.5) → 0x40100000 via the product[47] path. Also 0xBF000000 × 0x40800000 → 0xC0000000.
- 0x00000000 × 0x42F60000 → 0x00000000. Also 0x7F000000 × 0x7F000000 → 0x7F800000, and 0x7F800000 × 0x00000000 → 0x7FC00000.
- 0x3FC00001 × 0x3FC00001 → 0x40100001 with the macro undefined; 0x40100002 with FP_MUL_ROUND_EN defined.
- Backpressure: out_ready low for 10 cycles after out_valid rises → P_FP stable, in_ready=0, and in_valid pulses are ignored. Release → handshake, then a new acceptance the following cycle.
- Assert rst at cycle 12 of an operation → out_valid stays 0, in_ready=1 the next cycle, and a fresh 2.0×3.0 gives 0x40C00000 26 cycles after its acceptance.
